// File: rtl/regfile_wb_if.sv
// Write-back bus between the two producers (ALU, load unit), the arbiter and the
// register file write port.
//
// Signals:
//   req0_valid/ready/rd/data : ALU write-back request handshake
//   req1_valid/ready/rd/data : load write-back request handshake
//   reg_write_en/write_reg/write_data : registered register file write port
//
// Modports:
//   master : producer/register-file side (drives requests, observes ready and write port)
//   slave  : arbiter side
interface regfile_wb_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [REG_ADDR_W-1:0] req0_rd;
    logic [XLEN-1:0]       req0_data;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [REG_ADDR_W-1:0] req1_rd;
    logic [XLEN-1:0]       req1_data;

    logic                  reg_write_en;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [XLEN-1:0]       write_data;

    modport master (
        output req0_valid, req0_rd, req0_data,
        input  req0_ready,
        output req1_valid, req1_rd, req1_data,
        input  req1_ready,
        input  reg_write_en, write_reg, write_data
    );

    modport slave (
        input  req0_valid, req0_rd, req0_data,
        output req0_ready,
        input  req1_valid, req1_rd, req1_data,
        output req1_ready,
        output reg_write_en, write_reg, write_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and busy scoreboard in front of the register file write port.
//
// Two producers (req0 = ALU, req1 = load) compete for the single write port. One
// request is accepted per cycle, round-robin on conflict; the accepted write appears
// on the registered write port one cycle later. A per-register busy scoreboard is set
// at issue and cleared at write-back so the issue stage can detect RAW hazards.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : regfile_wb_if.slave (request handshakes + registered write port)
//   issue_valid : instruction with destination issue_rd issues this cycle
//   issue_rd    : destination register of the issuing instruction
//   sb_flush    : synchronous clear of all busy bits
//   rs1, rs2    : hazard query sources
//   hazard      : busy[rs1] | busy[rs2] (combinational, current state only)
//   busy_mask   : current scoreboard, bit 0 always 0
//
// Optional feature (macro REGFILE_WB_STATS_EN): adds saturating 16-bit counters
//   stat_grant0, stat_grant1 (transfers per requester) and stat_conflict (cycles with
//   both valids high).
module regfile_wb_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_REGS   = 2 ** REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_if.slave           bus,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  sb_flush,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  hazard,
    output logic [NUM_REGS-1:0]   busy_mask
`ifdef REGFILE_WB_STATS_EN
    ,
    output logic [15:0]           stat_grant0,
    output logic [15:0]           stat_grant1,
    output logic [15:0]           stat_conflict
`endif
);

    // Index of the most recent grant; reset to 1 so req0 wins the first conflict.
    logic                  last_grant_q, last_grant_d;

    logic                  grant0, grant1, xfer;
    logic [REG_ADDR_W-1:0] xfer_rd;
    logic [XLEN-1:0]       xfer_data;
    logic                  xfer_writes;

    logic                  we_q;
    logic [REG_ADDR_W-1:0] wreg_q;
    logic [XLEN-1:0]       wdata_q;

    logic [NUM_REGS-1:0]   busy_q, busy_d;

    // ---------------------------------------------------------------------------
    // Arbitration: only valids and last_grant feed the grant, never rd/data.
    // ---------------------------------------------------------------------------
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant0 = last_grant_q;
            grant1 = ~last_grant_q;
        end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
        end
    end

    assign xfer        = grant0 | grant1;
    assign xfer_rd     = grant0 ? bus.req0_rd : bus.req1_rd;
    assign xfer_data   = grant0 ? bus.req0_data : bus.req1_data;
    // Writes to x0 are accepted but never reach the register file.
    assign xfer_writes = xfer && (xfer_rd != '0);

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    always_comb begin
        last_grant_d = last_grant_q;
        if (xfer) begin
            last_grant_d = grant1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // ---------------------------------------------------------------------------
    // Registered write port: index/data hold when nothing is written.
    // ---------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= xfer_writes;
            if (xfer_writes) begin
                wreg_q  <= xfer_rd;
                wdata_q <= xfer_data;
            end
        end
    end

    assign bus.reg_write_en = we_q;
    assign bus.write_reg    = wreg_q;
    assign bus.write_data   = wdata_q;

    // ---------------------------------------------------------------------------
    // Scoreboard. Order matters: flush, then write-back clear, then issue set, so
    // a same-cycle issue always wins.
    // ---------------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        if (sb_flush) begin
            busy_d = '0;
        end else if (xfer_writes) begin
            busy_d[xfer_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_mask = busy_q;
    assign hazard    = busy_q[rs1] | busy_q[rs2];

`ifdef REGFILE_WB_STATS_EN
    // ---------------------------------------------------------------------------
    // Saturating activity counters.
    // ---------------------------------------------------------------------------
    logic [15:0] stat_grant0_q, stat_grant1_q, stat_conflict_q;
    logic        conflict;

    assign conflict = bus.req0_valid & bus.req1_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_grant0_q   <= '0;
            stat_grant1_q   <= '0;
            stat_conflict_q <= '0;
        end else begin
            if (grant0 && (stat_grant0_q != 16'hFFFF)) begin
                stat_grant0_q <= stat_grant0_q + 16'd1;
            end
            if (grant1 && (stat_grant1_q != 16'hFFFF)) begin
                stat_grant1_q <= stat_grant1_q + 16'd1;
            end
            if (conflict && (stat_conflict_q != 16'hFFFF)) begin
                stat_conflict_q <= stat_conflict_q + 16'd1;
            end
        end
    end

    assign stat_grant0   = stat_grant0_q;
    assign stat_grant1   = stat_grant1_q;
    assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter. Inputs change 1 time unit
// after a rising edge; combinational outputs are checked just before the next edge
// and registered outputs 1 unit after it.
module tb_regfile_wb_arbiter;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    logic                  clk;
    logic                  rst;
    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic                  sb_flush;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  hazard;
    logic [NUM_REGS-1:0]   busy_mask;
`ifdef REGFILE_WB_STATS_EN
    logic [15:0]           stat_grant0;
    logic [15:0]           stat_grant1;
    logic [15:0]           stat_conflict;
`endif

    int n_checks;
    int n_fails;

    regfile_wb_if #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) bus ();

    regfile_wb_arbiter #(
        .XLEN      (XLEN),
        .REG_ADDR_W(REG_ADDR_W),
        .NUM_REGS  (NUM_REGS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .sb_flush   (sb_flush),
        .rs1        (rs1),
        .rs2        (rs2),
        .hazard     (hazard),
        .busy_mask  (busy_mask)
`ifdef REGFILE_WB_STATS_EN
        ,
        .stat_grant0  (stat_grant0),
        .stat_grant1  (stat_grant1),
        .stat_conflict(stat_conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req0_rd    = '0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_rd    = '0;
        bus.req1_data  = '0;
        issue_valid    = 1'b0;
        issue_rd       = '0;
        sb_flush       = 1'b0;
        rs1            = '0;
        rs2            = '0;
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        idle_inputs();
        #2;

        // Reset state
        check("rst_we", 64'(bus.reg_write_en), 64'd0);
        check("rst_wreg", 64'(bus.write_reg), 64'd0);
        check("rst_wdata", 64'(bus.write_data), 64'd0);
        check("rst_busy", 64'(busy_mask), 64'd0);
        check("rst_hazard", 64'(hazard), 64'd0);
        do_reset();

        // 1: lone req0 write
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 5'd5;
        bus.req0_data  = 32'hDEADBEEF;
        #2;
        check("t1_rdy0", 64'(bus.req0_ready), 64'd1);
        check("t1_rdy1", 64'(bus.req1_ready), 64'd0);
        tick();
        bus.req0_valid = 1'b0;
        check("t1_we", 64'(bus.reg_write_en), 64'd1);
        check("t1_wreg", 64'(bus.write_reg), 64'd5);
        check("t1_wdata", 64'(bus.write_data), 64'hDEADBEEF);
        tick();
        check("t1_we_off", 64'(bus.reg_write_en), 64'd0);
        check("t1_wreg_hold", 64'(bus.write_reg), 64'd5);

        // 2: round-robin after reset, req0 wins first conflict
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd1; bus.req0_data = 32'h11;
        bus.req1_valid = 1'b1; bus.req1_rd = 5'd3; bus.req1_data = 32'h33;
        #2;
        check("t2_c1_rdy0", 64'(bus.req0_ready), 64'd1);
        check("t2_c1_rdy1", 64'(bus.req1_ready), 64'd0);
        tick();
        check("t2_wreg1", 64'(bus.write_reg), 64'd1);
        bus.req0_rd = 5'd2; bus.req0_data = 32'h22;
        #2;
        check("t2_c2_rdy0", 64'(bus.req0_ready), 64'd0);
        check("t2_c2_rdy1", 64'(bus.req1_ready), 64'd1);
        tick();
        check("t2_wreg3", 64'(bus.write_reg), 64'd3);
        check("t2_wdata3", 64'(bus.write_data), 64'h33);
        bus.req1_rd = 5'd4; bus.req1_data = 32'h44;
        #2;
        check("t2_c3_rdy0", 64'(bus.req0_ready), 64'd1);
        check("t2_c3_rdy1", 64'(bus.req1_ready), 64'd0);
        tick();
        check("t2_wreg2", 64'(bus.write_reg), 64'd2);
        bus.req0_valid = 1'b0;
        #2;
        check("t2_c4_rdy1", 64'(bus.req1_ready), 64'd1);
        tick();
        bus.req1_valid = 1'b0;
        check("t2_wreg4", 64'(bus.write_reg), 64'd4);
        check("t2_we4", 64'(bus.reg_write_en), 64'd1);

        // 3: issue sets busy, write-back clears it
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0; rs1 = 5'd7; rs2 = 5'd0;
        #1;
        check("t3_hazard", 64'(hazard), 64'd1);
        check("t3_busy7", 64'(busy_mask), 64'h80);
        bus.req1_valid = 1'b1; bus.req1_rd = 5'd7; bus.req1_data = 32'h77;
        #1;
        check("t3_rdy1", 64'(bus.req1_ready), 64'd1);
        check("t3_hazard_pre", 64'(hazard), 64'd1);
        tick();
        bus.req1_valid = 1'b0;
        check("t3_busy_clr", 64'(busy_mask), 64'd0);
        check("t3_hazard_clr", 64'(hazard), 64'd0);
        check("t3_wreg", 64'(bus.write_reg), 64'd7);

        // 4: same-cycle set and clear of rd 9 -> set wins
        issue_valid = 1'b1; issue_rd = 5'd9;
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd9; bus.req0_data = 32'h99;
        tick();
        issue_valid = 1'b0; bus.req0_valid = 1'b0;
        check("t4_set_wins", 64'(busy_mask), 64'h200);
        rs2 = 5'd9;
        #1;
        check("t4_hazard_rs2", 64'(hazard), 64'd1);
        // flush with concurrent issue of rd 12
        sb_flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd12;
        tick();
        sb_flush = 1'b0; issue_valid = 1'b0;
        check("t4_flush_issue", 64'(busy_mask), 64'h1000);
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd12; bus.req0_data = 32'hC0C0;
        tick();
        bus.req0_valid = 1'b0;
        check("t4_clr12", 64'(busy_mask), 64'd0);
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        issue_valid = 1'b0;
        check("t4_issue_x0", 64'(busy_mask), 64'd0);

        // 5: write to x0 accepted but suppressed
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd0; bus.req0_data = 32'h1234;
        #1;
        check("t5_rdy0", 64'(bus.req0_ready), 64'd1);
        tick();
        bus.req0_valid = 1'b0;
        check("t5_we", 64'(bus.reg_write_en), 64'd0);
        check("t5_wdata_hold", 64'(bus.write_data), 64'hC0C0);
        check("t5_wreg_hold", 64'(bus.write_reg), 64'd12);
        // reset while a write is presented and a busy bit is set
        bus.req1_valid = 1'b1; bus.req1_rd = 5'd10; bus.req1_data = 32'hAA;
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick();
        bus.req1_valid = 1'b0; issue_valid = 1'b0;
        check("t5_we_pre", 64'(bus.reg_write_en), 64'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_we", 64'(bus.reg_write_en), 64'd0);
        check("t5_rst_wreg", 64'(bus.write_reg), 64'd0);
        check("t5_rst_wdata", 64'(bus.write_data), 64'd0);
        check("t5_rst_busy", 64'(busy_mask), 64'd0);
        tick();
        rst = 1'b0;
        #1;

`ifdef REGFILE_WB_STATS_EN
        // 6: stats, 3 conflict cycles then 2 lone req1 transfers
        do_reset();
        check("t6_rst_c", 64'(stat_conflict), 64'd0);
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd1;
        bus.req1_valid = 1'b1; bus.req1_rd = 5'd2;
        tick();
        tick();
        tick();
        bus.req0_valid = 1'b0;
        tick();
        tick();
        bus.req1_valid = 1'b0;
        check("t6_conflict", 64'(stat_conflict), 64'd3);
        check("t6_grant0", 64'(stat_grant0), 64'd2);
        check("t6_grant1", 64'(stat_grant1), 64'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
        $finish;
    end

endmodule
